// File: rtl/rf_fwd_stage_pkg.sv
// Shared constants and types for the register-fetch / forward stage.
// Holds register-file geometry, the address and quadword types, and the NOP encoding.
package rf_fwd_stage_pkg;

  localparam int REG_W    = 128;
  localparam int NUM_REGS = 128;
  localparam int ADDR_W   = 7;
  localparam int OP_W     = 11;
  localparam int FORMAT_W = 3;
  localparam int IMM_W    = 18;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [0:REG_W-1]  qword_t;

  localparam logic [OP_W-1:0]     NOP_OP     = '0;
  localparam logic [FORMAT_W-1:0] NOP_FORMAT = '0;

  // Instruction fields carried through the stage to the execute units.
  typedef struct packed {
    logic [OP_W-1:0]     op;
    logic [FORMAT_W-1:0] format;
    reg_addr_t           rt_addr;
    logic [IMM_W-1:0]    imm;
    logic                reg_write;
  } instr_t;

  localparam instr_t NOP_INSTR = '{op: NOP_OP, format: NOP_FORMAT, rt_addr: '0,
                                   imm: '0, reg_write: 1'b0};

endpackage

// File: rtl/rf_fwd_stage_regfile.sv
// spu_regfile: NUM_REGS x REG_W register file, two write ports (odd wins on collision),
// three combinational read ports. Define RF_WB_BYPASS_EN to forward same-cycle writeback data.
module spu_regfile
  import rf_fwd_stage_pkg::*;
#(
  parameter int NUM_REGS = rf_fwd_stage_pkg::NUM_REGS,
  parameter int REG_W    = rf_fwd_stage_pkg::REG_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_even,
  input  reg_addr_t        waddr_even,
  input  logic [0:REG_W-1] wdata_even,
  input  logic             we_odd,
  input  reg_addr_t        waddr_odd,
  input  logic [0:REG_W-1] wdata_odd,
  input  reg_addr_t        raddr_a,
  input  reg_addr_t        raddr_b,
  input  reg_addr_t        raddr_c,
  output logic [0:REG_W-1] rdata_a,
  output logic [0:REG_W-1] rdata_b,
  output logic [0:REG_W-1] rdata_c
);

  logic [0:REG_W-1] regs [NUM_REGS];
  reg_addr_t        raddr [3];
  logic [0:REG_W-1] rdata [3];

  // NOTE: resetting every entry forces flops instead of a RAM macro; the stage requires a cleared file after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      // NOTE: non-blocking writes; the odd write is later in program order, so it wins a same-address collision.
      if (we_even) regs[waddr_even] <= wdata_even;
      if (we_odd)  regs[waddr_odd]  <= wdata_odd;
    end
  end

  assign raddr[0] = raddr_a;
  assign raddr[1] = raddr_b;
  assign raddr[2] = raddr_c;

  // NOTE: every always_comb output is assigned first so no path can infer a latch.
  always_comb begin
    for (int p = 0; p < 3; p++) begin
      rdata[p] = regs[raddr[p]];
`ifdef RF_WB_BYPASS_EN
      if (we_even && (waddr_even == raddr[p])) rdata[p] = wdata_even;
      if (we_odd  && (waddr_odd  == raddr[p])) rdata[p] = wdata_odd;
`endif
    end
  end

  assign rdata_a = rdata[0];
  assign rdata_b = rdata[1];
  assign rdata_c = rdata[2];

endmodule

// File: rtl/rf_fwd_stage.sv
// rf_fwd_stage: reads operands from spu_regfile and registers the instruction for execute,
// with stall (hold + operand refresh) and flush (nop). Optional bypass via RF_WB_BYPASS_EN.
module rf_fwd_stage
  import rf_fwd_stage_pkg::*;
#(
  parameter int NUM_REGS = rf_fwd_stage_pkg::NUM_REGS,
  parameter int REG_W    = rf_fwd_stage_pkg::REG_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OP_W-1:0]     op_in,
  input  logic [FORMAT_W-1:0] format_in,
  input  reg_addr_t           rt_addr_in,
  input  reg_addr_t           ra_addr_in,
  input  reg_addr_t           rb_addr_in,
  input  reg_addr_t           rc_addr_in,
  input  logic [IMM_W-1:0]    imm_in,
  input  logic                reg_write_in,
  input  logic                stall,
  input  logic                flush,
  input  logic [0:REG_W-1]    rt_wb_even,
  input  logic [0:REG_W-1]    rt_wb_odd,
  input  reg_addr_t           rt_addr_wb_even,
  input  reg_addr_t           rt_addr_wb_odd,
  input  logic                reg_write_wb_even,
  input  logic                reg_write_wb_odd,
  output logic [OP_W-1:0]     op,
  output logic [FORMAT_W-1:0] format,
  output reg_addr_t           rt_addr,
  output logic [IMM_W-1:0]    imm,
  output logic                reg_write,
  output logic [0:REG_W-1]    ra,
  output logic [0:REG_W-1]    rb,
  output logic [0:REG_W-1]    rc
);

  instr_t           instr_in, instr_q;
  reg_addr_t        ra_hold, rb_hold, rc_hold;
  reg_addr_t        rd_a, rd_b, rd_c;
  logic [0:REG_W-1] rdata_a, rdata_b, rdata_c;
  logic             hold_sel;

  assign instr_in = '{op: op_in, format: format_in, rt_addr: rt_addr_in,
                      imm: imm_in, reg_write: reg_write_in};

  // While stalled, operands are re-read from the held sources so late writebacks show up.
  assign hold_sel = stall && !flush;
  assign rd_a = hold_sel ? ra_hold : ra_addr_in;
  assign rd_b = hold_sel ? rb_hold : rb_addr_in;
  assign rd_c = hold_sel ? rc_hold : rc_addr_in;

  spu_regfile #(.NUM_REGS(NUM_REGS), .REG_W(REG_W)) u_regfile (
    .clk        (clk),
    .reset      (reset),
    .we_even    (reg_write_wb_even),
    .waddr_even (rt_addr_wb_even),
    .wdata_even (rt_wb_even),
    .we_odd     (reg_write_wb_odd),
    .waddr_odd  (rt_addr_wb_odd),
    .wdata_odd  (rt_wb_odd),
    .raddr_a    (rd_a),
    .raddr_b    (rd_b),
    .raddr_c    (rd_c),
    .rdata_a    (rdata_a),
    .rdata_b    (rdata_b),
    .rdata_c    (rdata_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= NOP_INSTR;
      ra      <= '0;
      rb      <= '0;
      rc      <= '0;
      ra_hold <= '0;
      rb_hold <= '0;
      rc_hold <= '0;
    end else if (flush) begin
      // A flushed slot is a nop; its held sources are cleared so a following stall stays a nop.
      instr_q <= NOP_INSTR;
      ra      <= '0;
      rb      <= '0;
      rc      <= '0;
      ra_hold <= '0;
      rb_hold <= '0;
      rc_hold <= '0;
    end else if (stall) begin
      ra <= rdata_a;
      rb <= rdata_b;
      rc <= rdata_c;
    end else begin
      instr_q <= instr_in;
      ra      <= rdata_a;
      rb      <= rdata_b;
      rc      <= rdata_c;
      ra_hold <= ra_addr_in;
      rb_hold <= rb_addr_in;
      rc_hold <= rc_addr_in;
    end
  end

  assign op        = instr_q.op;
  assign format    = instr_q.format;
  assign rt_addr   = instr_q.rt_addr;
  assign imm       = instr_q.imm;
  assign reg_write = instr_q.reg_write;

endmodule
